// File: rtl/bp_be_fp_recode_iter_pkg.sv
// Shared types and constants for the iterative IEEE-to-recoded FP writeback converter.
package bp_be_fp_recode_iter_pkg;

  typedef enum logic [1:0] {
    e_fp_dp   = 2'b00,
    e_fp_sp   = 2'b01,
    e_fp_hp   = 2'b10,
    e_fp_rsvd = 2'b11
  } bp_be_fp_tag_e;

  localparam int hp_float_width_gp = 16;
  localparam int hp_exp_width_gp   = 5;
  localparam int hp_sig_width_gp   = 11;
  localparam int dpath_width_gp    = 67;
  localparam int rec_width_gp      = 65;
  localparam int fract_width_gp    = 52;

  localparam logic [rec_width_gp-1:0]   dp_canonical_rec = 65'h0_e0080000_00000000;
  localparam logic [dpath_width_gp-1:0] dp_canonical_reg = {2'b00, dp_canonical_rec};
  localparam logic [dpath_width_gp-1:0] sp_canonical_reg = {2'b01, dp_canonical_rec};

  localparam logic [1:0] e_idle = 2'd0;
  localparam logic [1:0] e_norm = 2'd1;
  localparam logic [1:0] e_done = 2'd2;

  function automatic logic [dpath_width_gp-1:0] rec_pack(input logic [1:0] tag, input logic sign,
                                                         input logic [11:0] exp,
                                                         input logic [fract_width_gp-1:0] fract);
    return {tag, sign, exp, fract};
  endfunction

endpackage

// File: rtl/bp_be_fp_norm_iter.sv
// Chunked subnormal normaliser: strips shift_per_cycle_p leading zeros per cycle,
// then finishes inside the first non-zero chunk, dropping the hidden one.
module bp_be_fp_norm_iter
  import bp_be_fp_recode_iter_pkg::*;
#(
  parameter int shift_per_cycle_p = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      start_i,
  input  logic                      en_i,
  input  logic [fract_width_gp-1:0] fract_i,
  output logic                      done_o,
  output logic [fract_width_gp-1:0] fract_o,
  output logic [5:0]                nd_o
);

  logic [fract_width_gp-1:0]    fract_r;
  logic [5:0]                   cnt_r;
  logic [shift_per_cycle_p-1:0] chunk;
  logic [5:0]                   lz;

  assign chunk  = fract_r[fract_width_gp-1 -: shift_per_cycle_p];
  assign done_o = |chunk;

  // highest set bit in the chunk wins, hence ascending scan with overwrite
  always_comb begin
    lz = '0;
    for (int i = 0; i < shift_per_cycle_p; i++)
      if (chunk[i]) lz = 6'(shift_per_cycle_p - 1 - i);
  end

  assign nd_o    = cnt_r + lz;
  assign fract_o = fract_r << (lz + 6'd1);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      fract_r <= '0;
      cnt_r   <= '0;
    end else if (start_i) begin
      fract_r <= fract_i;
      cnt_r   <= '0;
    end else if (en_i && !done_o) begin
      fract_r <= fract_r << shift_per_cycle_p;
      cnt_r   <= cnt_r + 6'(shift_per_cycle_p);
    end
  end

endmodule

// File: rtl/bp_be_fp_recode_iter.sv
// IEEE dp/sp(/hp) bit pattern to tagged dp-recoded register value, iterative subnormals.
// Define BP_BE_FP_HALF_EN to decode tag 10 as half precision; otherwise it is reserved.
module bp_be_fp_recode_iter
  import bp_be_fp_recode_iter_pkg::*;
#(
  parameter int shift_per_cycle_p = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      flush_i,
  input  logic                      v_i,
  output logic                      ready_and_o,
  input  logic [63:0]               bits_i,
  input  logic [1:0]                tag_i,
  output logic                      v_o,
  input  logic                      ready_and_i,
  output logic [dpath_width_gp-1:0] reg_o
);

  logic [1:0]                state_r;
  logic [dpath_width_gp-1:0] reg_r;

  logic                      known, boxed, sign, exp_max, dec_sub;
  logic [10:0]               exp_field;
  logic [11:0]               off;
  logic [fract_width_gp-1:0] dec_fract;
  logic [dpath_width_gp-1:0] dec_reg;

  logic                      accept, norm_done;
  logic [fract_width_gp-1:0] norm_fract;
  logic [5:0]                norm_nd;

  // off is the rebias added to the raw exponent field; subnormals later subtract nd from it
  always_comb begin
    known     = 1'b0;
    boxed     = 1'b0;
    sign      = 1'b0;
    exp_field = '0;
    exp_max   = 1'b0;
    dec_fract = '0;
    off       = '0;
    dec_sub   = 1'b0;
    dec_reg   = dp_canonical_reg;
    case (tag_i)
      e_fp_dp: begin
        known = 1'b1; boxed = 1'b1; sign = bits_i[63];
        exp_field = bits_i[62:52]; exp_max = &bits_i[62:52];
        dec_fract = bits_i[51:0]; off = 12'd1025;
      end
      e_fp_sp: begin
        known = 1'b1; boxed = &bits_i[63:32]; sign = bits_i[31];
        exp_field = {3'b0, bits_i[30:23]}; exp_max = &bits_i[30:23];
        dec_fract = {bits_i[22:0], 29'b0}; off = 12'd1921;
      end
`ifdef BP_BE_FP_HALF_EN
      e_fp_hp: begin
        known = 1'b1; boxed = &bits_i[63:hp_float_width_gp]; sign = bits_i[15];
        exp_field = {6'b0, bits_i[14:10]}; exp_max = &bits_i[14:10];
        dec_fract = {bits_i[hp_sig_width_gp-2:0], 42'b0}; off = 12'd2033;
      end
`endif
      default: ;
    endcase
    if (known) begin
      if (!boxed)
        dec_reg = (tag_i == e_fp_sp) ? sp_canonical_reg : {tag_i, dp_canonical_rec};
      else if (exp_field == '0 && dec_fract == '0)
        dec_reg = rec_pack(tag_i, sign, 12'h000, '0);
      else if (exp_max && dec_fract == '0)
        dec_reg = rec_pack(tag_i, sign, 12'hc00, '0);
      else if (exp_max)
        dec_reg = rec_pack(tag_i, sign, 12'he00, {1'b1, dec_fract[50:0]});
      else if (exp_field == '0) begin
        dec_sub = 1'b1;
        dec_reg = rec_pack(tag_i, sign, off, '0);
      end else
        dec_reg = rec_pack(tag_i, sign, {1'b0, exp_field} + off, dec_fract);
    end
  end

  assign ready_and_o = ~flush_i & ((state_r == e_idle) | ((state_r == e_done) & ready_and_i));
  assign accept      = v_i & ready_and_o;
  assign v_o         = (state_r == e_done);
  assign reg_o       = reg_r;

  bp_be_fp_norm_iter #(.shift_per_cycle_p(shift_per_cycle_p)) norm (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .start_i   (accept & dec_sub),
    .en_i      (state_r == e_norm),
    .fract_i   (dec_fract),
    .done_o    (norm_done),
    .fract_o   (norm_fract),
    .nd_o      (norm_nd)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      reg_r   <= '0;
    end else if (flush_i) begin
      state_r <= e_idle;
    end else if (accept) begin
      state_r <= dec_sub ? e_norm : e_done;
      reg_r   <= dec_reg;
    end else if (state_r == e_norm && norm_done) begin
      state_r      <= e_done;
      reg_r[63:52] <= reg_r[63:52] - {6'b0, norm_nd};
      reg_r[51:0]  <= norm_fract;
    end else if (state_r == e_done && ready_and_i) begin
      state_r <= e_idle;
    end
  end

endmodule

// File: tb/tb_bp_be_fp_recode_iter.sv
// Randomised bench for bp_be_fp_recode_iter against a format-level reference model.
module tb_bp_be_fp_recode_iter;

  localparam int P = 4;
`ifdef BP_BE_FP_HALF_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif
  localparam logic [64:0] CANON = 65'h0_e0080000_00000000;

  logic        clk_i = 1'b0;
  logic        reset_n_i, flush_i, v_i, ready_and_i;
  logic [63:0] bits_i;
  logic [1:0]  tag_i;
  logic        ready_and_o, v_o;
  logic [66:0] reg_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit toggle_rdy = 1'b0;

  typedef struct {
    logic [66:0] r;
    int          due;
  } exp_t;
  exp_t q[$];

  bp_be_fp_recode_iter #(.shift_per_cycle_p(P)) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .flush_i     (flush_i),
    .v_i         (v_i),
    .ready_and_o (ready_and_o),
    .bits_i      (bits_i),
    .tag_i       (tag_i),
    .v_o         (v_o),
    .ready_and_i (ready_and_i),
    .reg_o       (reg_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Value-level reference: decode fields by format width, rebias the true exponent.
  function automatic logic [66:0] model(input logic [63:0] b, input logic [1:0] t, output int lat);
    int ew, fw, bias, e, nd;
    logic sign, boxed;
    logic [51:0] f;
    logic [11:0] rexp;
    lat = 1;
    if (t == 2'b11 || (t == 2'b10 && !HALF)) return {2'b00, CANON};
    case (t)
      2'b00:   begin ew = 11; fw = 52; end
      2'b01:   begin ew = 8;  fw = 23; end
      default: begin ew = 5;  fw = 10; end
    endcase
    boxed = (1 + ew + fw == 64) ||
            ((b >> (1 + ew + fw)) == (64'hFFFF_FFFF_FFFF_FFFF >> (1 + ew + fw)));
    if (!boxed) return {t, CANON};
    bias = (1 << (ew - 1)) - 1;
    sign = b[ew + fw];
    e    = int'((b >> fw) & ((64'd1 << ew) - 64'd1));
    f    = 52'((b & ((64'd1 << fw) - 64'd1)) << (52 - fw));
    if (e == 0 && f == 0) return {t, sign, 12'h000, 52'h0};
    if (e == (1 << ew) - 1) begin
      if (f == 0) return {t, sign, 12'hC00, 52'h0};
      return {t, sign, 12'hE00, f | (52'h1 << 51)};
    end
    if (e != 0) begin
      rexp = 12'(e - bias + 2048);
      return {t, sign, rexp, f};
    end
    nd = 0;
    while (!f[51 - nd]) nd++;
    rexp = 12'(1 - bias - nd - 1 + 2048);
    lat  = nd / P + 2;
    return {t, sign, rexp, 52'(f << (nd + 1))};
  endfunction

  function automatic logic [63:0] gen(input logic [1:0] t);
    int ew, fw, cls;
    logic [63:0] f, e, s, b;
    case (t)
      2'b01:   begin ew = 8; fw = 23; end
      2'b10:   begin ew = 5; fw = 10; end
      default: begin ew = 11; fw = 52; end
    endcase
    s   = 64'($urandom_range(0, 1));
    f   = {$urandom, $urandom} & ((64'd1 << fw) - 64'd1);
    cls = $urandom_range(0, 9);
    case (cls)
      0: begin e = 0; f = 0; end
      1: begin e = (64'd1 << ew) - 64'd1; f = 0; end
      2: begin e = (64'd1 << ew) - 64'd1; if (f == 0) f = 64'd1; end
      3, 4: begin
        e = 0;
        f = f >> $urandom_range(0, fw - 1);
        if (f == 0) f = 64'd1;
      end
      default: e = 64'($urandom_range(1, (1 << ew) - 2));
    endcase
    b = (s << (ew + fw)) | (e << fw) | f;
    if (fw != 52 && $urandom_range(0, 9) != 0) b = b | ~((64'd1 << (1 + ew + fw)) - 64'd1);
    return b;
  endfunction

  // Single compare process: protocol timing, ready and result contents every cycle.
  always @(negedge clk_i) begin
    bit ev, er;
    int lat;
    exp_t x;
    #2;
    if (reset_n_i) begin
      ev = (q.size() > 0) && (cyc >= q[0].due);
      chk("v_o", 67'(v_o), 67'(ev));
      er = !flush_i && (q.size() == 0 || (ev && ready_and_i));
      chk("ready_and_o", 67'(ready_and_o), 67'(er));
      if (ev) chk("reg_o", reg_o, q[0].r);
      if (flush_i) q.delete();
      else begin
        if (ev && ready_and_i) void'(q.pop_front());
        if (v_i && ready_and_o) begin
          x.r   = model(bits_i, tag_i, lat);
          x.due = cyc + lat;
          q.push_back(x);
        end
      end
    end else q.delete();
  end

  task automatic send(input logic [63:0] b, input logic [1:0] t);
    v_i = 1'b1; bits_i = b; tag_i = t;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (ready_and_o) begin
        @(negedge clk_i);
        v_i = 1'b0;
        if (toggle_rdy) ready_and_i = ~ready_and_i;
        return;
      end
      @(negedge clk_i);
      if (toggle_rdy) ready_and_i = ~ready_and_i;
    end
    checks++; errors++;
    $display("FAIL send_timeout: ready_and_o never seen for %h", b);
    v_i = 1'b0;
  endtask

  task automatic drain();
    toggle_rdy = 1'b0;
    ready_and_i = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (q.size() == 0) return;
    end
    checks++; errors++;
    $display("FAIL drain_timeout: %0d results outstanding", q.size());
  endtask

  initial begin
    int lat;
    bit took;
    logic [66:0] m;
    reset_n_i = 1'b0; flush_i = 1'b0; v_i = 1'b0; ready_and_i = 1'b1;
    bits_i = '0; tag_i = '0;

    // hand-derived values that pin the reference model
    m = model(64'h3FF0000000000000, 2'b00, lat);
    chk("model_dp_one", m, {2'b00, 65'h0_80000000_00000000});
    m = model(64'hFFFFFFFF3F800000, 2'b01, lat);
    chk("model_sp_one", m, {2'b01, 65'h0_80000000_00000000});
    m = model(64'h000000003F800000, 2'b01, lat);
    chk("model_sp_unboxed", m, {2'b01, 65'h0_e0080000_00000000});
    m = model(64'h0000000000000001, 2'b00, lat);
    chk("model_dp_min_sub", m, {2'b00, 1'b0, 12'h3CE, 52'h0});
    chk("model_dp_min_sub_lat", 67'(lat), 67'd14);
    m = model(64'hFFF0000000000000, 2'b00, lat);
    chk("model_dp_ninf", m, {2'b00, 65'h1_c0000000_00000000});
    m = model(64'h8000000000000000, 2'b00, lat);
    chk("model_dp_nzero", m, {2'b00, 65'h1_00000000_00000000});

    repeat (3) @(negedge clk_i);
    #2;
    chk("reset_v_o", 67'(v_o), 67'd0);
    chk("reset_ready", 67'(ready_and_o), 67'd1);
    chk("reset_reg_o", reg_o, 67'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    send(64'h3FF0000000000000, 2'b00);
    send(64'hFFFFFFFF3F800000, 2'b01);
    send(64'h000000003F800000, 2'b01);
    send(64'h0000000000000001, 2'b00);
    send(64'hFFF0000000000000, 2'b00);
    send(64'h8000000000000000, 2'b00);
    send(64'hFFFFFFFFFFFF3C00, 2'b10);
    send(64'hFFFFFFFFFFFF0001, 2'b10);
    send(64'h0123456789ABCDEF, 2'b11);
    send(64'hFFFFFFFF00000001, 2'b01);
    send(64'h7FF0000000000123, 2'b00);
    drain();

    // flush in the fifth e_norm cycle of a dp subnormal, then a fresh op
    send(64'h0000000000000001, 2'b00);
    repeat (4) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    send(64'h3FF0000000000000, 2'b00);
    drain();

    // eight back-to-back dp normals under a toggling consumer
    toggle_rdy = 1'b1;
    for (int i = 0; i < 8; i++)
      send({1'($urandom_range(0, 1)), 11'($urandom_range(1, 2046)), $urandom, 20'($urandom)}, 2'b00);
    drain();

    // reset in the middle of a subnormal: no output may appear
    send(64'h0000000000000003, 2'b00);
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    drain();

    took = 1'b1;
    repeat (4000) begin
      @(negedge clk_i);
      if (!v_i || took) begin
        v_i    = ($urandom_range(0, 3) != 0);
        tag_i  = 2'($urandom_range(0, 3));
        bits_i = gen(tag_i);
      end
      flush_i     = ($urandom_range(0, 49) == 0);
      ready_and_i = ($urandom_range(0, 3) != 0);
      #1 took = v_i && ready_and_o;
    end
    @(negedge clk_i);
    v_i = 1'b0;
    flush_i = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
